// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

   localparam int DM_AW = 12;
   localparam int DM_DW = 64;

   // One access takes exactly three cycles: pick, drive memory, report.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Requester identifier: 0 = CPU load/store, 1 = loader/DMA.
   typedef logic port_id_t;

   localparam port_id_t PORT0 = 1'b0;
   localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/dm_arb_rr.sv
// Two-way round-robin picker; the last-grant register lives in the parent.
module dm_arb_rr
   import dm_arb_pkg::*;
(
   input  logic [1:0] req,
   input  port_id_t   last,
   output logic       gnt_valid,
   output port_id_t   gnt_id
);

   // Lone requester wins outright; on contention the port not served last wins.
   // NOTE: every output gets a default first so no path through the block infers a latch.
   always_comb begin
      gnt_valid = |req;
      gnt_id    = PORT0;
      if (req == 2'b11) begin
         gnt_id = ~last;
      end else if (req[1]) begin
         gnt_id = PORT1;
      end
   end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for the 64-bit data memory.
// Optional per-port completion and contention counters: define DM_ARB_STATS_EN.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW    = DM_AW,
  parameter int DW    = DM_DW,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  output logic          dm_we,
  output logic          dm_sel,
  input  logic [DW-1:0] dm_rdata
`ifdef DM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] conflict
`endif
);

  state_t        state_q, state_d;
  port_id_t      last_q, last_d;
  port_id_t      id_q, id_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic          gnt_valid;
  port_id_t      gnt_id;

  dm_arb_rr u_rr (
    .req       ({req1, req0}),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Sequencer: next state, captured transaction and memory-side strobes.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    dm_sel   = 1'b0;
    dm_we    = 1'b0;
    done0    = 1'b0;
    done1    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = ACCESS;
          last_d  = gnt_id;
          id_d    = gnt_id;
          we_d    = (gnt_id == PORT1) ? we1    : we0;
          addr_d  = (gnt_id == PORT1) ? addr1  : addr0;
          wdata_d = (gnt_id == PORT1) ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        // Strobes come straight from state, so an async reset drops them at once.
        dm_sel  = 1'b1;
        dm_we   = we_q;
        state_d = DONE;
        if (!we_q) begin
          if (id_q == PORT1) rdata1_d = dm_rdata;
          else               rdata0_d = dm_rdata;
        end
      end
      DONE: begin
        done0   = (id_q == PORT0);
        done1   = (id_q == PORT1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; last-grant resets to port 1 so port 0 goes first.
  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= PORT1;
      id_q     <= PORT0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign dm_addr  = addr_q;
  assign dm_wdata = wdata_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

`ifdef DM_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [CNT_W-1:0] conflict_q, conflict_d;

  // Saturating counts of completions per port and of contended IDLE cycles.
  always_comb begin
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    conflict_d = conflict_q;
    if (state_q == DONE) begin
      if (id_q == PORT0 && cnt0_q != CNT_MAX) cnt0_d = cnt0_q + CNT_W'(1);
      if (id_q == PORT1 && cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CNT_W'(1);
    end
    if (state_q == IDLE && req0 && req1 && conflict_q != CNT_MAX) begin
      conflict_d = conflict_q + CNT_W'(1);
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      conflict_q <= '0;
    end else begin
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      conflict_q <= conflict_d;
    end
  end

  assign cnt0     = cnt0_q;
  assign cnt1     = cnt1_q;
  assign conflict = conflict_q;
`endif

endmodule
